// File: rtl/fetch_pkg.sv
// Shared types and default constants for the instruction fetch sequencer.
package fetch_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_HOLD = 2'd2,
      S_DROP = 2'd3
   } fetch_state_t;

   localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
   localparam int          DEF_TIMEOUT  = 16;

   // Fetch addresses are always word aligned; the low two bits are forced to 0.
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & ~32'h0000_0003;
   endfunction

endpackage

// File: rtl/fetch_buf.sv
// Holding register for the instruction presented to decode.
module fetch_buf
   import fetch_pkg::*;
(
   input  logic        clk,
   input  logic        clear,
   input  logic        load,
   input  logic        drop,
   input  logic [31:0] instr_in,
   input  logic [31:0] pcplus4_in,
   output logic [31:0] instr,
   output logic [31:0] pcplus4,
   output logic        valid
);

   // Load captures a new instruction; drop only invalidates it and keeps the
   // last word visible, which decode must ignore while valid is low.
   always_ff @(posedge clk) begin
      if (clear) begin
         instr   <= '0;
         pcplus4 <= '0;
         valid   <= 1'b0;
      end else if (load) begin
         instr   <= instr_in;
         pcplus4 <= pcplus4_in;
         valid   <= 1'b1;
      end else if (drop) begin
         valid   <= 1'b0;
      end
   end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: issues memory requests, buffers one instruction
// for decode, and handles redirects and request timeouts.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | one-cycle pause after reset before the first request
// REQ   | request outstanding at pc, waiting for imem_ack
// HOLD  | instruction buffered, waiting for decode to consume it
// DROP  | redirect seen mid-request; finish the old request, discard data
module fetch_sequencer
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEF_RESET_PC,
   parameter int          TIMEOUT  = DEF_TIMEOUT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stallD,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instrF,
   output logic [31:0] pcplus4F,
   output logic        validF,
   output logic        err
);

   localparam int            CW     = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TO_CNT = CW'(TIMEOUT);

   fetch_state_t  state, state_next;
   logic [31:0]   pc, pc_next;
   logic [31:0]   pend_pc, pend_next;
   logic [CW-1:0] cnt, cnt_next;
   logic          err_next;
   logic          buf_load, buf_drop;
   logic [31:0]   pc_inc;
   logic [31:0]   target;
   logic          entering;

   assign pc_inc    = pc + 32'd4;
   assign target    = word_align(redirect_pc);
   assign imem_req  = (state == S_REQ) || (state == S_DROP);
   assign imem_addr = pc;

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_next;
   end

   // Next-state, pc/pending-pc update and buffer control.
   always_comb begin
      state_next = state;
      pc_next    = pc;
      pend_next  = pend_pc;
      buf_load   = 1'b0;
      buf_drop   = 1'b0;
      case (state)
         S_IDLE: state_next = S_REQ;
         S_REQ: begin
            if (imem_ack && !redirect) begin
               buf_load   = 1'b1;
               state_next = S_HOLD;
            end else if (imem_ack) begin
               pc_next = target;
            end else if (redirect) begin
               // Request stays in flight; remember where to go afterwards.
               pend_next  = target;
               state_next = S_DROP;
            end
         end
         S_DROP: begin
            if (redirect) pend_next = target;
            if (imem_ack) begin
               pc_next    = redirect ? target : pend_pc;
               state_next = S_REQ;
            end
         end
         S_HOLD: begin
            if (redirect) begin
               buf_drop   = 1'b1;
               pc_next    = target;
               state_next = S_REQ;
            end else if (!stallD) begin
               buf_drop   = 1'b1;
               pc_next    = pc_inc;
               state_next = S_REQ;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   // Wait counter: restarts on each new request phase or ack, saturates.
   always_comb begin
      entering = (state_next != state) &&
                 ((state_next == S_REQ) || (state_next == S_DROP));
      if (entering || imem_ack)           cnt_next = '0;
      else if (imem_req && cnt != TO_CNT) cnt_next = cnt + 1'b1;
      else                                cnt_next = cnt;
      err_next = err || (cnt_next == TO_CNT);
   end

   // Datapath registers; err is sticky until reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc      <= RESET_PC;
         pend_pc <= '0;
         cnt     <= '0;
         err     <= 1'b0;
      end else begin
         pc      <= pc_next;
         pend_pc <= pend_next;
         cnt     <= cnt_next;
         err     <= err_next;
      end
   end

   fetch_buf u_buf (
      .clk        (clk),
      .clear      (reset),
      .load       (buf_load),
      .drop       (buf_drop),
      .instr_in   (imem_rdata),
      .pcplus4_in (pc_inc),
      .instr      (instrF),
      .pcplus4    (pcplus4F),
      .valid      (validF)
   );

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL set the first fetch address after reset.
REQ-002 Parameter TIMEOUT, default 16, SHALL set the number of unacknowledged request cycles before err is raised.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-005 stallD  input  1  SHALL, when high, mean decode cannot accept the presented instruction.
REQ-006 redirect  input  1  SHALL, when high, request a taken branch/jump to redirect_pc.
REQ-007 redirect_pc  input  32  SHALL be the target address; bits [1:0] SHALL be ignored and treated as 0.
REQ-008 imem_req  output  1  SHALL be the instruction memory request strobe.
REQ-009 imem_addr  output  32  SHALL be the word-aligned fetch address.
REQ-010 imem_ack  input  1  SHALL be the memory completion pulse, with imem_rdata valid in the same cycle.
REQ-011 imem_rdata  input  32  SHALL be the returned instruction word.
REQ-012 instrF  output  32  SHALL be the buffered instruction presented to decode.
REQ-013 pcplus4F  output  32  SHALL be the address of instrF plus 4.
REQ-014 validF  output  1  SHALL, when high, mean instrF/pcplus4F are valid.
REQ-015 err  output  1  SHALL be a sticky flag indicating a request timeout.

Function
REQ-016 The FSM SHALL have states IDLE, REQ, HOLD and DROP.
REQ-017 imem_req SHALL be high exactly in REQ and DROP; imem_addr SHALL equal pc in REQ and SHALL stay stable while imem_req is high and imem_ack is low.
REQ-018 IDLE SHALL go to REQ unconditionally after 1 cycle.
REQ-019 REQ with imem_ack and no redirect SHALL capture imem_rdata into instrF and pc+4 into pcplus4F, set validF, and go to HOLD.
REQ-020 REQ with redirect and imem_ack in the same cycle SHALL discard the data, load pc from redirect_pc and remain in REQ; the new address SHALL appear on the next cycle.
REQ-021 REQ with redirect and no imem_ack SHALL save redirect_pc as the pending pc and go to DROP; an in-flight request SHALL never be withdrawn.
REQ-022 In DROP, a further redirect SHALL overwrite the pending pc (last one wins).
REQ-023 DROP with imem_ack SHALL discard the data, load pc from the pending pc (or from redirect_pc if redirect is also high) and go to REQ.
REQ-024 HOLD with !stallD and no redirect SHALL consume the instruction: pc <= pc+4, validF <= 0, go to REQ.
REQ-025 HOLD with redirect SHALL take priority over consume and stall: it SHALL clear validF, load pc from redirect_pc and go to REQ.
REQ-026 HOLD with stallD and no redirect SHALL hold instrF, pcplus4F and validF unchanged.
REQ-027 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-028 The wait counter SHALL clear on entry to REQ or DROP and on imem_ack, increment each cycle imem_req is high without ack, and saturate at TIMEOUT.
REQ-029 err SHALL set when the counter reaches TIMEOUT and SHALL remain set until reset; the FSM SHALL keep waiting after err is set.
REQ-030 Best-case throughput SHALL be one instruction per 2 cycles with a 0-wait memory (ack in the first REQ cycle).

Reset
REQ-031 While reset is high: state = IDLE, pc = RESET_PC, imem_req = 0, validF = 0, instrF = 0, pcplus4F = 0, err = 0, counter = 0, pending pc = 0.
REQ-032 Reset asserted mid-request SHALL abandon the request; any imem_ack arriving during reset or in IDLE SHALL be ignored.

Structure
REQ-033 The state enum and the default RESET_PC/TIMEOUT constants SHALL live in shared package fetch_pkg.
REQ-034 The instrF/pcplus4F holding register (load enable and clear) SHALL be the sub-module fetch_buf; all other logic SHALL reside in fetch_sequencer.

Verification
REQ-035 Reset release, 0-wait memory returning 32'h2002_0005 at address 0 -> imem_req in cycle 1 with addr 0; validF in cycle 2 with instrF = 32'h2002_0005 and pcplus4F = 4.
REQ-036 stallD held 3 cycles in HOLD -> instrF, pcplus4F and validF unchanged and imem_req = 0; on stallD low -> next imem_addr = 4.
REQ-037 redirect_pc = 32'h40 while in REQ with ack delayed 2 cycles -> imem_addr stays 0 until ack, data is discarded, validF stays 0, next imem_addr = 32'h40.
REQ-038 redirect_pc = 32'h43 in HOLD with stallD high -> validF drops next cycle and imem_addr = 32'h40.
REQ-039 pc = 32'hFFFF_FFFC fetched and consumed -> pcplus4F = 0 and next imem_addr = 0.
REQ-040 ack withheld 16 cycles -> err rises on the 16th waiting cycle and stays high after a later ack; only reset clears it.
